// File: rtl/tensor_core_sequencer.sv
// rtl/tensor_core_sequencer.sv - program/data memory sequencer feeding the tensor core controller
// Fetches 64-bit instructions and issues operate, reset and multi-beat burst traffic under a ready stall.
module tensor_core_sequencer #(
  parameter  int DATA_WIDTH = 8,
  parameter  int IMEM_DEPTH = 1024,
  parameter  int DMEM_DEPTH = 1024,
  localparam int IMEM_AW    = $clog2(IMEM_DEPTH),
  localparam int DMEM_AW    = $clog2(DMEM_DEPTH),
  localparam int IW         = 2 * DATA_WIDTH
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic                         start_in,
  input  logic                         tensor_core_ready,
  input  logic signed [DATA_WIDTH-1:0] tensor_core_controller_output,
  input  logic                         host_we,
  input  logic                         host_sel,
  input  logic [15:0]                  host_addr,
  input  logic [63:0]                  host_wdata,
  output logic [DATA_WIDTH-1:0]        host_rdata,
  output logic                         reset_out,
  output logic [IW-1:0]                current_tensor_core_instruction,
  output logic                         busy,
  output logic                         done,
  output logic [IMEM_AW-1:0]           pc
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_OPERATE = 2'b01;
  localparam logic [1:0] OP_BURST   = 2'b10;
  localparam logic [1:0] OP_RESET   = 2'b11;

  logic [63:0]           r_imem [IMEM_DEPTH];
  logic [DATA_WIDTH-1:0] r_dmem [DMEM_DEPTH];

  logic [1:0]            r_state;
  logic [IMEM_AW-1:0]    r_pc;
  logic [7:0]            r_beat;
  logic [63:0]           r_instr;
  logic [DATA_WIDTH-1:0] r_host_rdata;

  logic [1:0]            w_op;
  logic [1:0]            w_sel;
  logic [7:0]            w_cnt;
  logic                  w_burst_wr;
  logic                  w_burst_rd;
  logic                  w_is_burst;
  logic                  w_halt;
  logic                  w_last_pc;
  logic [DMEM_AW-1:0]    w_beat_off;
  logic [DMEM_AW-1:0]    w_rd1_addr;
  logic [DMEM_AW-1:0]    w_rd2_addr;
  logic [DMEM_AW-1:0]    w_wr_addr;
  logic [IW-1:0]         w_instr_out;
  logic                  w_reset_op;
  logic                  w_advance;
  logic                  w_core_we;
  logic                  w_host_ok;
  logic                  w_imem_we;
  logic                  w_dmem_we;
  logic [DMEM_AW-1:0]    w_dmem_waddr;
  logic [DATA_WIDTH-1:0] w_dmem_wdata;
  logic                  w_unused_bits;

  assign w_op       = r_instr[1:0];
  assign w_sel      = r_instr[3:2];
  assign w_cnt      = r_instr[11:4];
  assign w_burst_wr = ((w_sel == 2'b01) || (w_sel == 2'b10)) && r_instr[15];
  assign w_burst_rd = ((w_sel == 2'b00) || (w_sel == 2'b10)) && r_instr[14];
  assign w_is_burst = (w_op == OP_BURST) && (w_burst_wr || w_burst_rd);
  assign w_halt     = (w_op == OP_NOP) && r_instr[15];
  assign w_last_pc  = (r_pc == IMEM_AW'(IMEM_DEPTH - 1));

  // Burst addresses wrap modulo the data memory depth by truncation.
  assign w_beat_off = DMEM_AW'(r_beat);
  assign w_rd1_addr = r_instr[16 +: DMEM_AW] + w_beat_off;
  assign w_rd2_addr = r_instr[32 +: DMEM_AW] + w_beat_off;
  assign w_wr_addr  = r_instr[48 +: DMEM_AW] + w_beat_off;

  always_comb begin
    w_instr_out = '0;
    w_reset_op  = 1'b0;
    w_advance   = 1'b0;
    if (r_state == S_EXEC) begin
      case (w_op)
        OP_NOP: begin
          if (!w_halt) begin
            w_instr_out = IW'(r_instr[15:0]);
            w_advance   = 1'b1;
          end
        end
        OP_OPERATE: begin
          w_instr_out = IW'(r_instr[15:0]);
          w_advance   = tensor_core_ready;
        end
        OP_RESET: begin
          w_reset_op = 1'b1;
          w_advance  = 1'b1;
        end
        OP_BURST: begin
          if (!w_is_burst) begin
            w_instr_out = IW'(r_instr[15:0]);
            w_advance   = 1'b1;
          end else begin
            if (w_burst_wr) w_instr_out = {r_dmem[w_rd1_addr], r_dmem[w_rd2_addr]};
            w_advance = tensor_core_ready && (r_beat == w_cnt);
          end
        end
        default: w_advance = 1'b0;
      endcase
    end
  end

  assign w_host_ok = (r_state == S_IDLE) && !reset_in && host_we;
  assign w_imem_we = w_host_ok && !host_sel;
  assign w_core_we = (r_state == S_EXEC) && !reset_in && w_is_burst && w_burst_rd && tensor_core_ready;

  always_comb begin
    w_dmem_we    = 1'b0;
    w_dmem_waddr = host_addr[DMEM_AW-1:0];
    w_dmem_wdata = host_wdata[DATA_WIDTH-1:0];
    if (w_core_we) begin
      w_dmem_we    = 1'b1;
      w_dmem_waddr = w_wr_addr;
      w_dmem_wdata = $unsigned(tensor_core_controller_output);
    end else if (w_host_ok && host_sel) begin
      w_dmem_we = 1'b1;
    end
  end

  always_ff @(posedge clock_in) begin
    if (w_imem_we) r_imem[host_addr[IMEM_AW-1:0]] <= host_wdata;
    if (w_dmem_we) r_dmem[w_dmem_waddr] <= w_dmem_wdata;
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_beat       <= '0;
      r_instr      <= '0;
      r_host_rdata <= '0;
    end else begin
      r_host_rdata <= r_dmem[host_addr[DMEM_AW-1:0]];
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_beat  <= '0;
          end
        end
        S_FETCH: begin
          r_instr <= r_imem[r_pc];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_halt) begin
            r_state <= S_DONE;
          end else if (w_advance) begin
            r_beat <= '0;
            if (w_last_pc) begin
              r_state <= S_DONE;
            end else begin
              r_pc    <= r_pc + 1'b1;
              r_state <= S_FETCH;
            end
          end else if (w_is_burst && tensor_core_ready) begin
            r_beat <= r_beat + 8'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_unused_bits = ^{r_instr, host_addr};

  assign current_tensor_core_instruction = w_instr_out;
  assign reset_out  = reset_in || w_reset_op;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign pc         = r_pc;
  assign host_rdata = r_host_rdata;

endmodule

// File: tb/tb_tensor_core_sequencer.sv
// tb/tb_tensor_core_sequencer.sv - scoreboard bench for tensor_core_sequencer
// Instruction-level reference model predicts a per-cycle trace that a negedge monitor consumes.
module tb_tensor_core_sequencer;
  localparam int DW   = 8;
  localparam int ID   = 32;
  localparam int DD   = 64;
  localparam int NCYC = 4096;
  localparam logic [63:0] HALT = 64'h8000;

  logic               clk = 1'b0;
  logic               reset_in;
  logic               start_in;
  logic               tc_ready;
  logic signed [DW-1:0] tc_out;
  logic               host_we;
  logic               host_sel;
  logic [15:0]        host_addr;
  logic [63:0]        host_wdata;
  logic [DW-1:0]      host_rdata;
  logic               reset_out;
  logic [2*DW-1:0]    instr_o;
  logic               busy;
  logic               done;
  logic [4:0]         pc;

  always #5 clk = ~clk;

  tensor_core_sequencer #(.DATA_WIDTH(DW), .IMEM_DEPTH(ID), .DMEM_DEPTH(DD)) dut (
    .clock_in(clk), .reset_in(reset_in), .start_in(start_in),
    .tensor_core_ready(tc_ready), .tensor_core_controller_output(tc_out),
    .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .reset_out(reset_out),
    .current_tensor_core_instruction(instr_o), .busy(busy), .done(done), .pc(pc)
  );

  typedef struct packed {
    logic [15:0] instr;
    logic        rst;
    logic        dn;
    logic        bz;
    logic [4:0]  pc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  bit          mon_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] m_imem [ID];
  logic [7:0]  m_dmem [DD];
  bit          rdy [NCYC];
  logic [7:0]  ov [NCYC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && q.size() > 0) begin
      mon_e = q.pop_front();
      check("instr", 64'(instr_o), 64'(mon_e.instr));
      check("reset_out", 64'(reset_out), 64'(mon_e.rst));
      check("done", 64'(done), 64'(mon_e.dn));
      check("busy", 64'(busy), 64'(mon_e.bz));
      check("pc", 64'(pc), 64'(mon_e.pc));
    end
  end

  task automatic push(input logic [15:0] i, input logic r, input logic d, input logic b, input int p);
    exp_t e;
    e.instr = i; e.rst = r; e.dn = d; e.bz = b; e.pc = p[4:0];
    q.push_back(e);
  endtask

  // Walks the program instruction by instruction, one trace entry per cycle after start.
  task automatic model_run();
    int k, p, cnt, a1, a2, wa;
    bit fin, wr, rd;
    logic [63:0] ins;
    logic [15:0] bv;
    k = 1; p = 0; fin = 1'b0;
    while (!fin) begin
      push(16'h0, 1'b0, 1'b0, 1'b1, p); k++;
      ins = m_imem[p];
      if (ins[1:0] == 2'b00 && ins[15]) begin
        push(16'h0, 1'b0, 1'b0, 1'b1, p); k++;
        fin = 1'b1;
      end else begin
        wr  = (ins[3:2] == 2'b01 || ins[3:2] == 2'b10) && ins[15];
        rd  = (ins[3:2] == 2'b00 || ins[3:2] == 2'b10) && ins[14];
        cnt = int'(ins[11:4]);
        a1  = int'(ins[31:16]); a2 = int'(ins[47:32]); wa = int'(ins[63:48]);
        if (ins[1:0] == 2'b01) begin
          while (!rdy[k] && k < NCYC - 2) begin push(ins[15:0], 1'b0, 1'b0, 1'b1, p); k++; end
          push(ins[15:0], 1'b0, 1'b0, 1'b1, p); k++;
        end else if (ins[1:0] == 2'b11) begin
          push(16'h0, 1'b1, 1'b0, 1'b1, p); k++;
        end else if (ins[1:0] == 2'b10 && (wr || rd)) begin
          for (int b = 0; b <= cnt; b++) begin
            bv = wr ? {m_dmem[(a1 + b) % DD], m_dmem[(a2 + b) % DD]} : 16'h0;
            while (!rdy[k] && k < NCYC - 2) begin push(bv, 1'b0, 1'b0, 1'b1, p); k++; end
            push(bv, 1'b0, 1'b0, 1'b1, p);
            if (rd) m_dmem[(wa + b) % DD] = ov[k];
            k++;
          end
        end else begin
          push(ins[15:0], 1'b0, 1'b0, 1'b1, p); k++;
        end
        if (p == ID - 1) fin = 1'b1;
        else p++;
      end
      if (k >= NCYC - 64) begin
        n_checks++; n_fail++;
        $display("FAIL model_overflow: trace length %0d limit %0d", k, NCYC - 64);
        fin = 1'b1;
      end
    end
    push(16'h0, 1'b0, 1'b1, 1'b1, p);
    push(16'h0, 1'b0, 1'b0, 1'b0, p);
  endtask

  task automatic host_write(input bit sel, input int addr, input logic [63:0] d);
    @(posedge clk); #1;
    host_we = 1'b1; host_sel = sel; host_addr = 16'(addr); host_wdata = d;
    @(posedge clk); #1;
    host_we = 1'b0;
    if (sel) m_dmem[addr % DD] = d[7:0];
    else     m_imem[addr % ID] = d;
  endtask

  task automatic read_dmem(input int addr, output logic [7:0] v);
    @(posedge clk); #1;
    host_addr = 16'(addr);
    @(posedge clk);
    @(negedge clk);
    v = host_rdata;
  endtask

  task automatic check_dmem_all();
    logic [7:0] v;
    for (int a = 0; a < DD; a++) begin
      read_dmem(a, v);
      check("dmem_readback", 64'(v), 64'(m_dmem[a]));
    end
  endtask

  task automatic fill_ready(input bit random_mode);
    for (int i = 0; i < NCYC; i++) begin
      rdy[i] = random_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      ov[i]  = random_mode ? 8'($urandom) : 8'h00;
    end
  endtask

  // Busy-time interference: a second start, a program write and a data write, all of which must be ignored.
  task automatic run_program(input bit interfere);
    int k, limit;
    logic [63:0] alt_i;
    logic [7:0]  alt_d;
    q.delete();
    model_run();
    limit = q.size() + 16;
    alt_i = (m_imem[1] == HALT) ? 64'h1 : HALT;
    alt_d = ~m_dmem[5];
    @(posedge clk); #1;
    start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0; k = 1; tc_ready = rdy[1]; tc_out = ov[1]; mon_en = 1'b1;
    while (q.size() > 0 && k < limit) begin
      @(posedge clk); #1;
      k++;
      tc_ready = rdy[k % NCYC]; tc_out = ov[k % NCYC];
      host_we = 1'b0; start_in = 1'b0;
      if (interfere && k == 2) begin
        start_in = 1'b1; host_we = 1'b1; host_sel = 1'b0; host_addr = 16'd1; host_wdata = alt_i;
      end
      if (interfere && k == 3) begin
        host_we = 1'b1; host_sel = 1'b1; host_addr = 16'd5; host_wdata = {56'h0, alt_d};
      end
    end
    host_we = 1'b0; start_in = 1'b0; mon_en = 1'b0; tc_ready = 1'b0;
    if (q.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL run_timeout: %0d trace entries left, expected 0", q.size());
      q.delete();
    end
    check_dmem_all();
  endtask

  task automatic random_program(input bit allow_halt);
    logic [63:0] r;
    int sel;
    for (int a = 0; a < ID; a++) begin
      r   = {$urandom, $urandom};
      sel = $urandom_range(0, 9);
      if (sel <= 1)      r = {r[63:16], 1'b0, r[14:2], 2'b00};
      else if (sel <= 3) r = {r[63:2], 2'b01};
      else if (sel == 4) r = {r[63:2], 2'b11};
      else if (sel <= 8) r = {r[63:12], 6'h0, r[5:4], r[3:2], 2'b10};
      else if (allow_halt) r = {r[63:16], 1'b1, r[14:2], 2'b00};
      else               r = {r[63:2], 2'b01};
      host_write(1'b0, a, r);
    end
    for (int i = 0; i < 8; i++) host_write(1'b1, $urandom_range(0, DD - 1), 64'($urandom));
  endtask

  initial begin
    logic [7:0] v;
    reset_in = 1'b1; start_in = 1'b0; tc_ready = 1'b0; tc_out = '0;
    host_we = 1'b0; host_sel = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_done", 64'(done), 64'h0);
    check("reset_instr", 64'(instr_o), 64'h0);
    check("reset_pc", 64'(pc), 64'h0);
    check("reset_rdata", 64'(host_rdata), 64'h0);
    check("reset_out_in_reset", 64'(reset_out), 64'h1);
    @(posedge clk); #1;
    reset_in = 1'b0;
    @(negedge clk);
    check("reset_out_released", 64'(reset_out), 64'h0);

    for (int a = 0; a < ID; a++) host_write(1'b0, a, HALT);
    for (int a = 0; a < DD; a++) host_write(1'b1, a, 64'($urandom));

    // OPERATE then HALT with ready tied high
    host_write(1'b0, 0, 64'h0000_0000_0000_0041);
    host_write(1'b0, 1, HALT);
    fill_ready(1'b0);
    run_program(1'b1);

    // 3-beat write burst pairing dmem[0..2] with dmem[8..10]
    for (int i = 0; i < 3; i++) begin
      host_write(1'b1, i, 64'(i + 1));
      host_write(1'b1, 8 + i, 64'(i + 4));
    end
    host_write(1'b0, 0, 64'h0000_0008_0000_8026);
    fill_ready(1'b0);
    run_program(1'b1);

    // 2-beat read burst wrapping from the last data word to word 0
    host_write(1'b0, 0, 64'h003F_0000_0000_4012);
    fill_ready(1'b0);
    ov[2] = 8'h7F; ov[3] = 8'h80;
    run_program(1'b1);
    read_dmem(DD - 1, v);
    check("wrap_last_word", 64'(v), 64'h7F);
    read_dmem(0, v);
    check("wrap_first_word", 64'(v), 64'h80);

    // OPERATE stalled for 4 cycles
    host_write(1'b0, 0, 64'h1234_0000_0000_0041);
    fill_ready(1'b0);
    for (int i = 2; i <= 5; i++) rdy[i] = 1'b0;
    run_program(1'b1);

    // RESET opcode pulses reset_out once
    host_write(1'b0, 0, 64'h3);
    fill_ready(1'b0);
    run_program(1'b1);

    // reset_in in the middle of an 8-beat write burst
    host_write(1'b0, 0, 64'h0000_0010_0000_8076);
    @(posedge clk); #1;
    start_in = 1'b1; tc_ready = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midburst_busy", 64'(busy), 64'h1);
    check("midburst_beat1", 64'(instr_o), 64'({m_dmem[1], m_dmem[17]}));
    @(posedge clk); #1;
    reset_in = 1'b1;
    @(negedge clk);
    check("midburst_reset_out", 64'(reset_out), 64'h1);
    @(posedge clk); #1;
    reset_in = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_done", 64'(done), 64'h0);
    check("abort_instr", 64'(instr_o), 64'h0);
    check("abort_reset_out", 64'(reset_out), 64'h0);
    check("abort_pc", 64'(pc), 64'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'h0);
    end
    tc_ready = 1'b0;
    check_dmem_all();

    for (int r = 0; r < 5; r++) begin
      random_program(r != 4);
      fill_ready(1'b1);
      run_program(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time exceeded limit");
    $fatal(1);
  end

endmodule
